udp_echo: RTL

- Store-and-forward packet buffer on the application side of the UDP stack.
- Consumes the UDP receive payload stream and discards errored or overflowing packets.
- Replays each good packet unchanged on the UDP transmit payload stream, giving a hardware echo/loopback server.
- Input side has no backpressure, because the UDP receive stream ignores tready. The block therefore absorbs bytes at full rate and drops whole packets when space runs out.

---
 rtl/udp_echo.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/udp_echo.sv
// udp_echo: store-and-forward echo buffer for the UDP payload streams.
// Every received byte is absorbed at full rate. A packet is replayed on the
// transmit stream only if it arrives complete and error-free, with room in
// both the byte RAM and the length queue. Any other packet is dropped whole.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_s_tvalid/tdata/tlast  receive payload stream (never backpressured)
//   i_s_tuser               sampled with tlast, 1 = bad packet
//   o_s_tready              constant 1
//   o_m_tvalid/tdata/tlast  transmit payload stream
//   i_m_tready              transmit backpressure
//   o_m_tuser               constant 0
//   o_pkt_count             packets committed (wraps)
//   o_drop_count            packets discarded (wraps)
//
// Output FSM
//   state   | meaning
//   S_IDLE  | waiting for a committed length; pops it and reads first byte
//   S_FETCH | RAM latency cycle; first byte loads into the output register
//   S_SEND  | presenting bytes; next byte is always prefetched in r_ram_q

module udp_echo #(
  parameter int DEPTH_LOG2 = 11,
  parameter int NPKT_LOG2  = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_s_tvalid,
  input  logic [7:0] i_s_tdata,
  input  logic       i_s_tlast,
  input  logic       i_s_tuser,
  output logic       o_s_tready,
  output logic       o_m_tvalid,
  input  logic       i_m_tready,
  output logic [7:0] o_m_tdata,
  output logic       o_m_tlast,
  output logic       o_m_tuser,
  output logic [15:0] o_pkt_count,
  output logic [15:0] o_drop_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int NPKT  = 1 << NPKT_LOG2;

  typedef logic [DEPTH_LOG2-1:0] ptr_t;
  typedef logic [DEPTH_LOG2:0]   len_t;
  typedef logic [NPKT_LOG2:0]    qptr_t;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SEND} state_t;

  logic [7:0] r_mem [DEPTH];
  logic [7:0] r_ram_q;

  ptr_t   r_wr_ptr;
  ptr_t   r_commit_ptr;
  ptr_t   r_rd_ptr;
  len_t   r_len;
  logic   r_drop;

  len_t   r_lq [NPKT];
  qptr_t  r_lq_wr;
  qptr_t  r_lq_rd;

  state_t r_state;
  len_t   r_remain;

  ptr_t   w_used;
  logic   w_space_full;
  qptr_t  w_lq_count;
  logic   w_lq_full;
  logic   w_lq_empty;
  logic   w_wr_en;
  logic   w_discard;
  ptr_t   w_wr_ptr_nxt;
  len_t   w_len_nxt;
  logic   w_hs;
  ptr_t   w_raddr;

  assign o_s_tready = 1'b1;
  assign o_m_tuser  = 1'b0;

  // One slot is kept unused so a full buffer is distinguishable from empty.
  assign w_used       = r_wr_ptr - r_rd_ptr;
  assign w_space_full = (w_used == ptr_t'(DEPTH - 1));
  assign w_lq_count   = r_lq_wr - r_lq_rd;
  assign w_lq_full    = (w_lq_count == qptr_t'(NPKT));
  assign w_lq_empty   = (r_lq_wr == r_lq_rd);

  assign w_wr_en      = i_s_tvalid && !w_space_full && !r_drop;
  assign w_wr_ptr_nxt = r_wr_ptr + ptr_t'(1);
  assign w_len_nxt    = r_len + len_t'(1);
  // !w_wr_en also covers a packet already marked for dropping.
  assign w_discard    = i_s_tuser || !w_wr_en || w_lq_full;

  assign w_hs = o_m_tvalid && i_m_tready;

  // Read address runs one byte ahead of rd_ptr while sending, two ahead on
  // a handshake, so the byte after the one on the bus is always waiting.
  always_comb begin
    w_raddr = r_rd_ptr;
    case (r_state)
      S_FETCH: w_raddr = r_rd_ptr + ptr_t'(1);
      S_SEND:  w_raddr = w_hs ? r_rd_ptr + ptr_t'(2) : r_rd_ptr + ptr_t'(1);
      default: w_raddr = r_rd_ptr;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_en && !i_reset) begin
      r_mem[r_wr_ptr] <= i_s_tdata;
    end
    r_ram_q <= r_mem[w_raddr];
  end

  // Write side: accumulate, then commit or rewind on the tlast beat.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr     <= '0;
      r_commit_ptr <= '0;
      r_len        <= '0;
      r_drop       <= 1'b0;
      r_lq_wr      <= '0;
      o_pkt_count  <= '0;
      o_drop_count <= '0;
    end else if (i_s_tvalid) begin
      if (w_wr_en) begin
        r_wr_ptr <= w_wr_ptr_nxt;
        r_len    <= w_len_nxt;
      end else begin
        r_drop <= 1'b1;
      end
      if (i_s_tlast) begin
        r_drop <= 1'b0;
        r_len  <= '0;
        if (w_discard) begin
          r_wr_ptr     <= r_commit_ptr;
          o_drop_count <= o_drop_count + 16'd1;
        end else begin
          r_commit_ptr                 <= w_wr_ptr_nxt;
          r_lq[r_lq_wr[NPKT_LOG2-1:0]] <= w_len_nxt;
          r_lq_wr                      <= r_lq_wr + qptr_t'(1);
          o_pkt_count                  <= o_pkt_count + 16'd1;
        end
      end
    end
  end

  // Read side / output FSM.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_rd_ptr   <= '0;
      r_lq_rd    <= '0;
      r_remain   <= '0;
      o_m_tvalid <= 1'b0;
      o_m_tlast  <= 1'b0;
      o_m_tdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_lq_empty) begin
            r_remain <= r_lq[r_lq_rd[NPKT_LOG2-1:0]];
            r_lq_rd  <= r_lq_rd + qptr_t'(1);
            r_state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          o_m_tvalid <= 1'b1;
          o_m_tdata  <= r_ram_q;
          o_m_tlast  <= (r_remain == len_t'(1));
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (w_hs) begin
            r_rd_ptr <= r_rd_ptr + ptr_t'(1);
            if (o_m_tlast) begin
              o_m_tvalid <= 1'b0;
              o_m_tlast  <= 1'b0;
              r_state    <= S_IDLE;
            end else begin
              r_remain  <= r_remain - len_t'(1);
              o_m_tdata <= r_ram_q;
              o_m_tlast <= (r_remain == len_t'(2));
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
